prescaler_multi: RTL and testbench

PRESCALER_MULTI -- requirements
Module: prescaler_multi

---
 rtl/prescaler_pkg.sv | 15 +
 rtl/prescaler_chan.sv | 75 +++++++
 rtl/prescaler_multi.sv | 54 +++++
 tb/tb_prescaler_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared definitions for the multi-channel prescaler: output mode encodings
// and the channel-select width helper.
package prescaler_pkg;

  typedef enum logic {
    MODE_PULSE = 1'b0,
    MODE_WAVE  = 1'b1
  } mode_e;

  // Channel-select width, never narrower than one bit so a single-channel build still has a port.
  function automatic int chan_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/prescaler_chan.sv
// One divider channel: up-counter against an active limit, double-buffered
// limit/mode configuration, registered tick and square-wave outputs.
module prescaler_chan
  import prescaler_pkg::*;
#(
  parameter int          WIDTH     = 20,
  parameter int unsigned RESET_LIM = 416666
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_lim,
  input  logic             wr_mode,
  output logic             tick,
  output logic             wave,
  output logic             pending
);

  localparam logic [WIDTH-1:0] RST_LIM = WIDTH'(RESET_LIM);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] act_lim;
  logic [WIDTH-1:0] sh_lim;
  mode_e            act_mode;
  mode_e            sh_mode;
  logic             wrap;

  assign wrap = en && (count == act_lim);

  // Sync and wrap both promote the pre-edge shadow; a write on the same edge
  // lands in the shadow afterwards and therefore stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      act_lim  <= RST_LIM;
      act_mode <= MODE_PULSE;
      sh_lim   <= RST_LIM;
      sh_mode  <= MODE_PULSE;
      pending  <= 1'b0;
      tick     <= 1'b0;
      wave     <= 1'b0;
    end else begin
      if (sync) begin
        count    <= '0;
        tick     <= 1'b0;
        wave     <= 1'b0;
        act_lim  <= sh_lim;
        act_mode <= sh_mode;
        pending  <= 1'b0;
      end else if (wrap) begin
        count    <= '0;
        tick     <= 1'b1;
        act_lim  <= sh_lim;
        act_mode <= sh_mode;
        pending  <= 1'b0;
        // The wave follows the mode that takes effect at this wrap.
        wave     <= (sh_mode == MODE_WAVE) ? ~wave : 1'b0;
      end else if (en) begin
        count <= count + WIDTH'(1);
        tick  <= 1'b0;
      end else begin
        tick <= 1'b0;
      end

      if (wr) begin
        sh_lim  <= wr_lim;
        sh_mode <= mode_e'(wr_mode);
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prescaler_multi.sv
// Bank of NCH independent prescaler channels sharing enable, sync and a
// single configuration write port; this level only decodes the write target.
module prescaler_multi
  import prescaler_pkg::*;
#(
  parameter int          WIDTH     = 20,
  parameter int          NCH       = 4,
  parameter int unsigned RESET_LIM = 416666,
  localparam int         CHW       = chan_width(NCH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [CHW-1:0]   i_wr_ch,
  input  logic [WIDTH-1:0] i_wr_lim,
  input  logic             i_wr_mode,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_wave,
  output logic [NCH-1:0]   o_pending
);

  logic [NCH-1:0] wr_sel;

  // Out-of-range channel numbers match no index and are silently dropped.
  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_wr_en && (i_wr_ch == CHW'(k))) begin
        wr_sel[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    prescaler_chan #(
      .WIDTH     (WIDTH),
      .RESET_LIM (RESET_LIM)
    ) u_chan (
      .clk     (i_clk),
      .rst_n   (i_reset),
      .en      (i_en),
      .sync    (i_sync),
      .wr      (wr_sel[g]),
      .wr_lim  (i_wr_lim),
      .wr_mode (i_wr_mode),
      .tick    (o_tick[g]),
      .wave    (o_wave[g]),
      .pending (o_pending[g])
    );
  end

endmodule

// File: tb/tb_prescaler_multi.sv
// Bench for prescaler_multi: directed scenarios then randomized traffic, all
// checked against a countdown-style reference model of each channel.
module tb_prescaler_multi;

  localparam int WIDTH     = 8;
  localparam int NCH       = 2;
  localparam int RESET_LIM = 4;
  localparam int CHW       = 1;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_en;
  logic             i_sync;
  logic             i_wr_en;
  logic [CHW-1:0]   i_wr_ch;
  logic [WIDTH-1:0] i_wr_lim;
  logic             i_wr_mode;
  logic [NCH-1:0]   o_tick;
  logic [NCH-1:0]   o_wave;
  logic [NCH-1:0]   o_pending;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: cycles remaining until the next tick, plus config copies.
  int mRem[NCH];
  int mLim[NCH];
  int mMode[NCH];
  int mShLim[NCH];
  int mShMode[NCH];
  int mPend[NCH];
  int mTick[NCH];
  int mWave[NCH];

  prescaler_multi #(
    .WIDTH     (WIDTH),
    .NCH       (NCH),
    .RESET_LIM (RESET_LIM)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (i_en),
    .i_sync    (i_sync),
    .i_wr_en   (i_wr_en),
    .i_wr_ch   (i_wr_ch),
    .i_wr_lim  (i_wr_lim),
    .i_wr_mode (i_wr_mode),
    .o_tick    (o_tick),
    .o_wave    (o_wave),
    .o_pending (o_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) begin
      mRem[k]    = RESET_LIM;
      mLim[k]    = RESET_LIM;
      mMode[k]   = 0;
      mShLim[k]  = RESET_LIM;
      mShMode[k] = 0;
      mPend[k]   = 0;
      mTick[k]   = 0;
      mWave[k]   = 0;
    end
  endtask

  task automatic modelStep(input logic en, input logic sync, input logic wrEn,
                           input int wrCh, input int lim, input int mode);
    for (int k = 0; k < NCH; k++) begin
      if (sync) begin
        mLim[k]  = mShLim[k];
        mMode[k] = mShMode[k];
        mRem[k]  = mLim[k];
        mTick[k] = 0;
        mWave[k] = 0;
        mPend[k] = 0;
      end else if (en) begin
        if (mRem[k] == 0) begin
          mTick[k] = 1;
          mLim[k]  = mShLim[k];
          mMode[k] = mShMode[k];
          mRem[k]  = mLim[k];
          mPend[k] = 0;
          mWave[k] = (mMode[k] == 1) ? 1 - mWave[k] : 0;
        end else begin
          mTick[k] = 0;
          mRem[k]  = mRem[k] - 1;
        end
      end else begin
        mTick[k] = 0;
      end
      if (wrEn && wrCh == k) begin
        mShLim[k]  = lim;
        mShMode[k] = mode;
        mPend[k]   = 1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    logic [NCH-1:0] expTick, expWave, expPend;
    for (int k = 0; k < NCH; k++) begin
      expTick[k] = (mTick[k] != 0);
      expWave[k] = (mWave[k] != 0);
      expPend[k] = (mPend[k] != 0);
    end
    checkOutput({tag, "_tick"}, 32'(o_tick), 32'(expTick));
    checkOutput({tag, "_wave"}, 32'(o_wave), 32'(expWave));
    checkOutput({tag, "_pend"}, 32'(o_pending), 32'(expPend));
  endtask

  // Drive one cycle of inputs at the falling edge, let the model see the
  // rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input string tag, input logic en, input logic sync,
                               input logic wrEn, input int wrCh, input int lim, input int mode);
    i_en      = en;
    i_sync    = sync;
    i_wr_en   = wrEn;
    i_wr_ch   = CHW'(wrCh);
    i_wr_lim  = WIDTH'(lim);
    i_wr_mode = (mode != 0);
    @(posedge i_clk);
    modelStep(en, sync, wrEn, wrCh, lim, mode);
    @(negedge i_clk);
    compareAll(tag);
  endtask

  task automatic runIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Advance until ch0's up-count would equal target; a missed target counts as a failure.
  task automatic waitCh0Count(input string tag, input int target);
    int guard = 0;
    while ((mLim[0] - mRem[0]) != target && guard < 64) begin
      applyStimulus(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      guard++;
    end
    if (guard >= 64) checkOutput({tag, "_timeout"}, 32'(guard), 32'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear with no edge.
  task automatic pulseReset(input string tag);
    #1;
    i_reset = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "_tick"}, 32'(o_tick), 32'd0);
    checkOutput({tag, "_wave"}, 32'(o_wave), 32'd0);
    checkOutput({tag, "_pend"}, 32'(o_pending), 32'd0);
    #1;
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset   = 1'b0;
    i_en      = 1'b0;
    i_sync    = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_ch   = '0;
    i_wr_lim  = '0;
    i_wr_mode = 1'b0;
    modelReset();
    repeat (2) @(negedge i_clk);
    compareAll("reset");
    i_reset = 1'b1;

    $display("[TB] basic period after reset");
    for (int e = 1; e <= 15; e++) begin
      applyStimulus("basic", 1'b1, 1'b0, 1'b0, 0, 0, 0);
      if (e % 5 == 0) checkOutput("basic_edge_tick", 32'(o_tick), 32'd3);
    end

    $display("[TB] ch1 limit 0 wave mode");
    runIdle("mid", 2);
    applyStimulus("wr_ch1", 1'b1, 1'b0, 1'b1, 1, 0, 1);
    checkOutput("wr_ch1_pending", 32'(o_pending[1]), 32'd1);
    runIdle("ch1_fast", 10);

    $display("[TB] write on ch0 wrap edge");
    waitCh0Count("wrap_wait", mLim[0]);
    applyStimulus("wr_on_wrap", 1'b1, 1'b0, 1'b1, 0, 2, 0);
    checkOutput("wr_on_wrap_tick0", 32'(o_tick[0]), 32'd1);
    checkOutput("wr_on_wrap_pend0", 32'(o_pending[0]), 32'd1);
    runIdle("ch0_short", 12);

    $display("[TB] enable hold");
    waitCh0Count("hold_wait", 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("hold", 1'b0, 1'b0, 1'b0, 0, 0, 0);
      checkOutput("hold_tick", 32'(o_tick), 32'd0);
    end
    runIdle("after_hold", 6);

    $display("[TB] pending write then sync");
    applyStimulus("wr_ch0_7", 1'b1, 1'b0, 1'b1, 0, 7, 0);
    applyStimulus("wr_ch1_4", 1'b1, 1'b0, 1'b1, 1, 4, 0);
    applyStimulus("sync", 1'b0, 1'b1, 1'b0, 0, 0, 0);
    checkOutput("sync_pend", 32'(o_pending), 32'd0);
    runIdle("after_sync", 12);

    $display("[TB] reset mid-period");
    applyStimulus("wr_pre_rst", 1'b1, 1'b0, 1'b1, 1, 6, 1);
    waitCh0Count("rst_wait", 3);
    pulseReset("async_rst");
    runIdle("after_rst", 10);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      logic en, sync, wrEn;
      en   = ($urandom_range(0, 9) < 8);
      sync = ($urandom_range(0, 49) == 0);
      wrEn = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 149) == 0) pulseReset("rand_rst");
      applyStimulus("rand", en, sync, wrEn, int'($urandom_range(0, NCH - 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
